ifetch: RTL
===========

// Module: ifetch
// PURPOSE
//   Instruction fetch unit: initiator side of the instruction-memory read port.
//   Owns the PC and drives imem_addr; imem_rdata returns combinationally in the same cycle.
//   Registers {pc, instr} into the IF/ID stage with a valid/ready handshake to decode.
//   Accepts branch/jump redirects and a halt request from the core.
// PARAMETERS
//   RESET_PC   32'h00000000  PC loaded on reset
//   CNT_W      32            width of the retired-fetch counter
// PORTS
//   clk             in   1      core clock; all state updates on posedge
//   rst_n           in   1      asynchronous, active-low reset
//   imem_addr       out  32     word-aligned fetch address; equals pc_q
//   imem_rdata      in   32     instruction word, combinational from imem_addr
//   id_valid        out  1      IF/ID register holds a valid instruction
//   id_ready        in   1      decode accepts the instruction this cycle
//   id_instr        out  32     fetched instruction
//   id_pc           out  32     address of id_instr
//   redirect_valid  in   1      load redirect_pc; squash the in-flight fetch
//   redirect_pc     in   32     branch/jump target
//   halt_req        in   1      stop fetching after the current handshake
//   halted          out  1      FSM is in HALT
//   fetch_cnt       out  CNT_W  count of id_valid&&id_ready handshakes
// BEHAVIOUR
//   Reset: pc_q=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, fetch_cnt=0, state=BOOT.
//   FSM: BOOT -> RUN after one cycle (no fetch is captured in BOOT).
//        RUN -> HALT when halt_req=1 (sampled at posedge); HALT -> RUN only on redirect_valid.
//   advance = !id_valid || id_ready. In RUN with advance: id_instr<=imem_rdata,
//     id_pc<=pc_q, id_valid<=1, pc_q<=pc_q+4 (32-bit, wraps 0xFFFFFFFC->0).
//   Stall (id_valid && !id_ready): pc_q, id_instr, id_pc held stable; imem_addr unchanged.
//   Redirect (any state, highest priority): pc_q<=redirect_pc; id_valid<=0 next cycle
//     (one-cycle bubble) even if decode stalls; the target instruction is valid the
//     following cycle. A held instruction is discarded without a handshake.
//   redirect_valid with halt_req in the same cycle: redirect wins; state=RUN.
//   HALT: no new capture; a held instruction stays valid until accepted, then id_valid=0.
//   fetch_cnt increments on every id_valid&&id_ready and wraps at 2^CNT_W.
//   Async reset mid-stall or mid-redirect returns every output to its reset value.
// CONFIGURATION
//   IFETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 does not load the PC;
//     FSM enters HALT, id_valid<=0, and output fault (1 bit, sticky until reset) goes to 1.
//   Not defined: the fault port is absent; redirect_pc[1:0] is forced to 2'b00.
// STRUCTURE
//   mips_pkg: RESET_PC default, INSTR_W=32, NOP_INSTR=32'h00000000,
//     and the fetch state encoding {BOOT,RUN,HALT}.
//   No sub-module; the PC, IF/ID register, FSM and counter are one always_ff group each.
// TESTING
//   1 Reset release, id_ready=1 -> id_valid=0 in BOOT; then (pc,instr) = (0x0,0x00000000),
//     (0x4,0x20080004), (0x8,0x2009000D) on consecutive cycles; fetch_cnt=3.
//   2 At id_pc=0x0C hold id_ready=0 for 3 cycles -> id_instr=0x01095020, imem_addr=0x10 stable;
//     release -> next id_instr=0x010A5020.
//   3 redirect_valid, redirect_pc=0x38 during a stall -> one-cycle bubble, then
//     (0x38,0x0128402A), (0x3C,0x1100FFFE); the stalled word is never counted.
//   4 halt_req at id_pc=0x24 -> halted=1, the held word drains, id_valid=0; redirect to 0x0
//     -> RUN, (0x0,0x00000000).
//   5 Run past the program end -> (0x40,0x00000000) fetched as NOP; PC 0xFFFFFFFC wraps to 0x0.
//   6 With IFETCH_ALIGN_CHECK_EN, redirect_pc=0x3A -> fault=1, halted=1, PC unchanged;
//     without the macro, the same redirect -> fetch at 0x38.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: reset PC, instruction width, NOP word,
// fetch FSM state encoding and a word-alignment helper.
package mips_pkg;

  localparam logic [31:0]         RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned         INSTR_W      = 32;
  localparam logic [INSTR_W-1:0]  NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits so the PC always stays on a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory combinationally and
// registers {pc, instr} into IF/ID behind a valid/ready handshake to decode.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (adds the sticky misaligned-redirect fault).
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic               fault
`endif
);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic               id_valid_q;
  logic [INSTR_W-1:0] id_instr_q;
  logic [31:0]        id_pc_q;
  logic [CNT_W-1:0]   fetch_cnt_q;

  logic        advance;
  logic        capture;
  logic        handshake;
  logic        redir_ok;
  logic        redir_bad;
  logic [31:0] redir_target;

  assign advance      = !id_valid_q || id_ready;
  assign handshake    = id_valid_q && id_ready;
  // A redirect squashes the in-flight fetch, so no capture happens in that cycle.
  assign capture      = (state_q == RUN) && advance && !redirect_valid;
  assign redir_target = align_word(redirect_pc);
  assign redir_ok     = redirect_valid && !redir_bad;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fault     = fault_q;

  // Sticky fault flag: set by any misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redir_bad) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic unused_redirect_lsbs;

  assign redir_bad            = 1'b0;
  // Low address bits are dropped by align_word in this build.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign halted    = (state_q == HALT);
  assign fetch_cnt = fetch_cnt_q;

  // PC: redirect has priority, otherwise step by one word on each capture (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redir_ok) begin
      pc_q <= redir_target;
    end else if (capture) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // IF/ID register: redirect bubbles, capture loads, a handshake without capture drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      id_valid_q <= 1'b0;
    end else if (capture) begin
      id_valid_q <= 1'b1;
      id_instr_q <= imem_rdata;
      id_pc_q    <= pc_q;
    end else if (handshake) begin
      id_valid_q <= 1'b0;
    end
  end

  // Fetch FSM: a single boot cycle, then RUN until halted; only a redirect restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else if (redir_bad) begin
      state_q <= HALT;
    end else if (redir_ok) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt_req) state_q <= HALT;
        HALT:    state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

  // Retired-fetch counter: one per accepted instruction, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if (handshake) begin
      fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end
  end

endmodule
